// File: rtl/mskdemux2_fifo_gadget_if.sv
// mskdemux2_fifo_gadget_if
//   Bundles the input and output handshakes of the masked 1-to-2 demux.
//   Masked words use share-interleaved packing: bit i of the word occupies
//   [i*d+d-1 : i*d], one bit per share.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds its payload stable while
// valid is 1 and ready is 0. in_ready never depends combinationally on
// out_ready.
//
// Signals
//   in_valid  / in_ready   : input word handshake (a_input, s_input, rnd)
//   a_input   [d*word]     : masked data word
//   s_input   [d]          : masked select bit
//   rnd       [word*d*(d-1)/2] : fresh randomness, one slice per data bit
//   rnd_valid              : rnd holds unused randomness
//   out_valid / out_ready  : FIFO head handshake
//   out0, out1 [d*word]    : masked a AND NOT s, masked a AND s
//
// Modports: master = producer/consumer side, slave = the gadget.
interface mskdemux2_fifo_gadget_if #(
  parameter int d    = 2,
  parameter int word = 13
) ();
  logic                          in_valid;
  logic                          in_ready;
  logic [d*word-1:0]             a_input;
  logic [d-1:0]                  s_input;
  logic [word*d*(d-1)/2-1:0]     rnd;
  logic                          rnd_valid;
  logic                          out_valid;
  logic                          out_ready;
  logic [d*word-1:0]             out0;
  logic [d*word-1:0]             out1;

  modport master (
    output in_valid, a_input, s_input, rnd, rnd_valid, out_ready,
    input  in_ready, out_valid, out0, out1
  );

  modport slave (
    input  in_valid, a_input, s_input, rnd, rnd_valid, out_ready,
    output in_ready, out_valid, out0, out1
  );
endinterface

// File: rtl/mskdemux2_fifo_gadget.sv
// mskdemux2_fifo_gadget
//   Masked 1-to-2 demultiplexer. For every accepted word:
//     out1 = a AND s     (one HPC2 AND gadget per data bit)
//     out0 = a XOR out1  (= a AND NOT s, share-wise XOR)
//   Results go through a fixed 3-cycle pipeline into a share-preserving
//   output FIFO. Input acceptance is credit based: a word is only accepted
//   when the FIFO is guaranteed to have room for it when it arrives.
//
// Ports
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mskdemux2_fifo_gadget_if.slave (see interface for signals)
//
// Optional build macro
//   MSKDEMUX_ZEROIZE_EN : popped FIFO entries are cleared to 0 at the pop
//                         edge, and out0/out1 read 0 while out_valid = 0.
module mskdemux2_fifo_gadget #(
  parameter int d     = 2,
  parameter int word  = 13,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mskdemux2_fifo_gadget_if.slave        bus
);
  localparam int N  = d * word;
  localparam int P  = d * (d - 1) / 2;
  localparam int AW = $clog2(DEPTH);

  // Index of the random bit shared by share pair (i, j) within one data bit.
  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * (2 * d - lo - 1) / 2 + (hi - lo - 1);
  endfunction

  logic                acc;
  logic                wr;
  logic                pop;
  logic                out_valid;
  logic [AW+1:0]       occ;

  logic [N-1:0]        a_s1_q, a_s2_q, a_s3_q;
  logic [d-1:0]        s_s1_q;
  logic [word*P-1:0]   rnd_s1_q;
  logic [N-1:0]        out1_w, out0_w;

  logic [AW:0]         count_q;
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [1:0]          infl_q;
  logic [2:0]          vp_q;
  logic [N-1:0]        mem0_q [DEPTH];
  logic [N-1:0]        mem1_q [DEPTH];

  // Credit: words in the pipe plus words stored must leave room for one more.
  assign occ          = {1'b0, count_q} + {{AW{1'b0}}, infl_q};
  assign bus.in_ready = rst_n & bus.rnd_valid & (occ < (AW+2)'(DEPTH));
  assign acc          = bus.in_valid & bus.in_ready;
  assign wr           = vp_q[2];
  assign out_valid    = (count_q != '0);
  assign pop          = out_valid & bus.out_ready;
  assign bus.out_valid = out_valid;

  // Stage 1 captures only on accept so randomness is consumed once per word.
  // Data registers are not reset: the cleared valid pipe hides their content.
  always_ff @(posedge clk) begin
    if (acc) begin
      a_s1_q   <= bus.a_input;
      s_s1_q   <= bus.s_input;
      rnd_s1_q <= bus.rnd;
    end
    a_s2_q <= a_s1_q;
    a_s3_q <= a_s2_q;
  end

  // HPC2 AND per bit: s (inb) and randomness are refreshed one cycle ahead,
  // a (ina) enters one cycle later, and every product term is registered
  // before the share's terms are XORed together.
  for (genvar w = 0; w < word; w++) begin : g_bit
    for (genvar i = 0; i < d; i++) begin : g_share
      logic [d-1:0] term;
      for (genvar j = 0; j < d; j++) begin : g_term
        if (i == j) begin : g_own
          logic b_q, v_q;
          always_ff @(posedge clk) begin
            b_q <= s_s1_q[i];
            v_q <= a_s2_q[w*d+i] & b_q;
          end
          assign term[j] = v_q;
        end else begin : g_cross
          localparam int RI = w * P + pair_idx(i, j);
          logic z_q, r_q, u_q, v_q;
          always_ff @(posedge clk) begin
            z_q <= s_s1_q[j] ^ rnd_s1_q[RI];
            r_q <= rnd_s1_q[RI];
            u_q <= ~a_s2_q[w*d+i] & r_q;
            v_q <= a_s2_q[w*d+i] & z_q;
          end
          assign term[j] = u_q ^ v_q;
        end
      end
      assign out1_w[w*d+i] = ^term;
    end
  end

  // Same share index on both operands: no cross-share mixing here.
  assign out0_w = a_s3_q ^ out1_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      infl_q  <= '0;
      vp_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem0_q[k] <= '0;
        mem1_q[k] <= '0;
      end
    end else begin
      vp_q <= {vp_q[1:0], acc};

      unique case ({acc, wr})
        2'b10:   infl_q <= infl_q + 2'd1;
        2'b01:   infl_q <= infl_q - 2'd1;
        default: ;
      endcase

      unique case ({wr, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase

      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
`ifdef MSKDEMUX_ZEROIZE_EN
        mem0_q[rptr_q] <= '0;
        mem1_q[rptr_q] <= '0;
`endif
      end

      // The credit rule keeps wptr != rptr whenever write and pop coincide.
      if (wr) begin
        mem0_q[wptr_q] <= out0_w;
        mem1_q[wptr_q] <= out1_w;
        wptr_q         <= wptr_q + AW'(1);
      end
    end
  end

`ifdef MSKDEMUX_ZEROIZE_EN
  assign bus.out0 = out_valid ? mem0_q[rptr_q] : '0;
  assign bus.out1 = out_valid ? mem1_q[rptr_q] : '0;
`else
  assign bus.out0 = mem0_q[rptr_q];
  assign bus.out1 = mem1_q[rptr_q];
`endif
endmodule
